char_buffer_arbiter: RTL and testbench

Loads incoming ciphertext characters into the processor's data RAM without clobbering processor accesses. Characters arrive on a valid/ready byte stream and are queued in a small FIFO. They are written one per word into the RAM character buffer (words `BASE_ADDR` upward) only on cycles when the CPU is not using the RAM port. On a terminator character or a full buffer, the block writes the character count to a length word and signals done. The block sits between the processor's dmem port and the RAM and owns the RAM's write mux.

---
 rtl/char_buffer_arbiter_if.sv | 26 ++
 rtl/char_buffer_arbiter.sv | 113 +++++++++++
 tb/tb_char_buffer_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/char_buffer_arbiter_if.sv
// rtl/char_buffer_arbiter_if.sv - character stream, CPU dmem and RAM port bundle for char_buffer_arbiter
interface char_buffer_arbiter_if;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        buf_clear;
  logic        cpu_mem_active;
  logic        cpu_wren;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        ram_wren;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic [6:0]  char_count;
  logic        buf_done;

  modport master (
    output char_data, char_valid, buf_clear, cpu_mem_active, cpu_wren, cpu_addr, cpu_data,
    input  char_ready, ram_wren, ram_addr, ram_data, char_count, buf_done
  );

  modport slave (
    input  char_data, char_valid, buf_clear, cpu_mem_active, cpu_wren, cpu_addr, cpu_data,
    output char_ready, ram_wren, ram_addr, ram_data, char_count, buf_done
  );
endinterface

// File: rtl/char_buffer_arbiter.sv
// rtl/char_buffer_arbiter.sv - loads queued characters into RAM on CPU-idle cycles, then writes the length word
module char_buffer_arbiter #(
  parameter int         BASE_ADDR  = 1500,
  parameter int         BUF_SIZE   = 108,
  parameter int         LEN_ADDR   = 1499,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
  input logic                   clock,
  input logic                   reset,
  char_buffer_arbiter_if.slave  bus
);
  localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0]  BUF_SZ   = 7'(BUF_SIZE);
  localparam logic [11:0] BASE12   = 12'(BASE_ADDR);
  localparam logic [11:0] LEN12    = 12'(LEN_ADDR);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {FILL, LEN, DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   fifo_count;
  logic [6:0]       count;
  logic             done;

  logic             cpu_free, fifo_empty, push, pop, inc;
  logic             ldr_wren;
  logic [11:0]      ldr_addr;
  logic [31:0]      ldr_data;
  logic [7:0]       head;

  assign head       = fifo_mem[rd_ptr];
  assign cpu_free   = !bus.cpu_mem_active && !bus.cpu_wren;
  assign fifo_empty = (fifo_count == '0);

  // Registered occupancy only: a full FIFO refuses a push even when it pops this cycle.
  assign bus.char_ready = (fifo_count < DEPTH) && (state != DONE) && !bus.buf_clear;
  assign push           = bus.char_valid && bus.char_ready;

  assign bus.char_count = count;
  assign bus.buf_done   = done;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    inc        = 1'b0;
    ldr_wren   = 1'b0;
    ldr_addr   = BASE12 + {5'b0, count};
    ldr_data   = {24'b0, head};
    if (bus.buf_clear) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (cpu_free && !fifo_empty) begin
            pop = 1'b1;
            if (head == TERM_CHAR) begin
              state_next = LEN;
            end else begin
              ldr_wren = 1'b1;
              inc      = 1'b1;
              if (count + 7'd1 == BUF_SZ) state_next = LEN;
            end
          end
        end
        LEN: begin
          if (cpu_free) begin
            ldr_wren   = 1'b1;
            ldr_addr   = LEN12;
            ldr_data   = {25'b0, count};
            state_next = DONE;
          end
        end
        default: ;
      endcase
    end

    bus.ram_wren = ldr_wren ? 1'b1     : bus.cpu_wren;
    bus.ram_addr = ldr_wren ? ldr_addr : bus.cpu_addr;
    bus.ram_data = ldr_wren ? ldr_data : bus.cpu_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      count      <= '0;
      done       <= 1'b0;
    end else if (bus.buf_clear) begin
      state      <= FILL;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      count      <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (inc && count != BUF_SZ) count <= count + 7'd1;
      if (state == LEN && state_next == DONE) done <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.char_data;
  end
endmodule

// File: tb/tb_char_buffer_arbiter.sv
// tb/tb_char_buffer_arbiter.sv - scoreboard bench for char_buffer_arbiter with a queue-based loader model
module tb_char_buffer_arbiter;
  localparam int         BASE = 1500;
  localparam int         SIZE = 108;
  localparam int         LENA = 1499;
  localparam logic [7:0] TERM = 8'h0A;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  char_buffer_arbiter_if bus();
  char_buffer_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [43:0] cpu_q[$];
  logic [43:0] ldr_q[$];
  logic [31:0] mem_img [int];
  int          m_count = 0;
  bit          m_finished = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memv(int a);
    if (mem_img.exists(a)) return mem_img[a];
    return 32'hxxxxxxxx;
  endfunction

  // Buffer semantics: characters fill words from BASE; terminator or capacity emits the length word.
  task automatic model_accept(logic [7:0] c);
    if (m_finished) return;
    if (c == TERM) begin
      ldr_q.push_back({12'(LENA), 25'b0, 7'(m_count)});
      m_finished = 1'b1;
    end else begin
      ldr_q.push_back({12'(BASE + m_count), 24'b0, c});
      m_count++;
      if (m_count == SIZE) begin
        ldr_q.push_back({12'(LENA), 25'b0, 7'(m_count)});
        m_finished = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    ldr_q.delete();
    m_count    = 0;
    m_finished = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.cpu_wren) begin
        check("cpu_write_passes", bus.ram_wren, 1'b1);
        if (cpu_q.size() > 0) check("cpu_write", {bus.ram_addr, bus.ram_data}, cpu_q.pop_front());
      end else if (bus.ram_wren) begin
        check("loader_only_when_cpu_idle", bus.cpu_mem_active, 1'b0);
        if (ldr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_loader_write: got addr %0d data %0h expected none", bus.ram_addr, bus.ram_data);
        end else begin
          check("loader_write", {bus.ram_addr, bus.ram_data}, ldr_q.pop_front());
        end
      end
      if (bus.ram_wren) mem_img[int'(bus.ram_addr)] = bus.ram_data;
    end
  end

  task automatic cyc(bit v, logic [7:0] d, bit act, bit wr, logic [11:0] a, logic [31:0] wd,
                     bit clr, output bit accepted);
    bus.char_valid     = v;
    bus.char_data      = d;
    bus.cpu_mem_active = act | wr;
    bus.cpu_wren       = wr;
    bus.cpu_addr       = a;
    bus.cpu_data       = wd;
    bus.buf_clear      = clr;
    if (wr) cpu_q.push_back({a, wd});
    if (clr) model_clear();
    @(negedge clock);
    accepted = v && bus.char_ready;
    if (accepted) model_accept(d);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, a);
  endtask

  task automatic push_free(logic [7:0] c);
    bit a;
    cyc(1'b1, c, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, a);
  endtask

  task automatic do_clear();
    bit a;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, a);
    mem_img.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int acc;
    int offered;
    bus.char_valid = 0; bus.char_data = 0; bus.buf_clear = 0;
    bus.cpu_mem_active = 0; bus.cpu_wren = 1'b1; bus.cpu_addr = 12'h123; bus.cpu_data = 32'h55AA_1234;
    #12;
    check("reset_char_ready", bus.char_ready, 1'b1);
    check("reset_char_count", bus.char_count, 7'd0);
    check("reset_buf_done", bus.buf_done, 1'b0);
    check("reset_ram_follows_cpu", {bus.ram_wren, bus.ram_addr, bus.ram_data}, {1'b1, 12'h123, 32'h55AA_1234});
    bus.cpu_wren = 0;
    @(posedge clock); #1 reset = 1'b0;

    // Basic fill
    push_free("A"); push_free("B"); push_free("C"); push_free(TERM);
    idle(5);
    check("basic_ram1500", memv(1500), 32'd65);
    check("basic_ram1501", memv(1501), 32'd66);
    check("basic_ram1502", memv(1502), 32'd67);
    check("basic_len", memv(1499), 32'd3);
    check("basic_done", bus.buf_done, 1'b1);
    check("basic_count", bus.char_count, 7'd3);
    check("done_not_ready", bus.char_ready, 1'b0);

    // Clear and restart
    do_clear();
    check("clear_count", bus.char_count, 7'd0);
    check("clear_done", bus.buf_done, 1'b0);
    push_free("Q"); push_free(TERM);
    idle(5);
    check("restart_ram1500", memv(1500), 32'd81);
    check("restart_len", memv(1499), 32'd1);

    // CPU priority
    do_clear();
    cyc(1'b1, "X", 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    check("prio_x_accepted", a, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 12'd100, 32'hDEADBEEF, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    check("prio_x_not_yet", memv(1500) === 32'd88, 1'b0);
    bus.cpu_mem_active = 1'b0;
    @(negedge clock);
    check("prio_first_free_cycle", {bus.ram_wren, bus.ram_addr, bus.ram_data}, {1'b1, 12'd1500, 32'd88});
    @(posedge clock); #1;
    check("prio_cpu_store", memv(100), 32'hDEADBEEF);
    push_free(TERM);
    idle(4);
    check("prio_len", memv(1499), 32'd1);

    // FIFO full
    do_clear();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h61 + 8'(i), 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
      if (a) acc++;
    end
    check("full_accepted_four", acc, 4);
    check("full_not_ready", bus.char_ready, 1'b0);
    cyc(1'b1, "e", 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, a);
    check("full_no_push_on_pop_cycle", a, 1'b0);
    cyc(1'b1, "e", 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, a);
    check("full_push_after_pop", a, 1'b1);
    idle(6);
    push_free(TERM);
    idle(4);
    check("full_fifth_char", memv(1504), 32'h65);
    check("full_len", memv(1499), 32'd5);

    // Capacity
    do_clear();
    acc = 0;
    offered = 0;
    while (acc < 110 && offered < 200) begin
      cyc(1'b1, 8'h41 + 8'(acc % 26), 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, a);
      if (a) acc++;
      offered++;
    end
    idle(8);
    check("cap_last_char", memv(1607), 32'(8'h41 + 8'(107 % 26)));
    check("cap_no_overflow", mem_img.exists(1608), 1'b0);
    check("cap_len", memv(1499), 32'd108);
    check("cap_done", bus.buf_done, 1'b1);
    check("cap_not_ready", bus.char_ready, 1'b0);
    check("cap_count", bus.char_count, 7'd108);

    // Async reset mid-fill
    do_clear();
    push_free("M");
    cyc(1'b1, "N", 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    cyc(1'b1, "O", 1'b1, 1'b0, 12'd0, 32'h0, 1'b0, a);
    bus.char_valid = 1'b0; bus.cpu_mem_active = 1'b0; bus.cpu_wren = 1'b0;
    bus.cpu_addr = 12'd777; bus.cpu_data = 32'hCAFE_0001;
    #2 reset = 1'b1;
    model_clear();
    #1;
    check("arst_count", bus.char_count, 7'd0);
    check("arst_done", bus.buf_done, 1'b0);
    check("arst_ram_to_cpu", {bus.ram_wren, bus.ram_addr, bus.ram_data}, {1'b0, 12'd777, 32'hCAFE_0001});
    check("arst_ready", bus.char_ready, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    mem_img.delete();
    push_free("R"); push_free(TERM);
    idle(5);
    check("arst_restart_char", memv(1500), 32'd82);
    check("arst_restart_len", memv(1499), 32'd1);

    // Randomized traffic against the model
    do_clear();
    for (int i = 0; i < 2500; i++) begin
      bit v, act, wr, clr;
      logic [7:0] d;
      v   = ($urandom % 4) != 0;
      d   = (($urandom % 16) == 0) ? TERM : 8'(8'h20 + ($urandom % 64));
      act = ($urandom % 3) == 0;
      wr  = act && ($urandom % 2);
      clr = ($urandom % 150) == 0;
      cyc(v, d, act, wr, 12'($urandom % 1400), $urandom, clr, a);
    end
    idle(20);
    check("rand_loader_drained", ldr_q.size(), 0);
    check("rand_cpu_drained", cpu_q.size(), 0);
    check("rand_count", bus.char_count, 7'(m_count));
    check("rand_done", bus.buf_done, m_finished);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
